// File: rtl/regfile_rob_tagged.sv
// Architectural register file with a per-register ROB tag (register status table).
// N_CP commit ports, one rename port, flush, and N_RP combinational read ports with optional commit bypass.
module regfile_rob_tagged #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int ROBEN_W = 5,
  parameter int N_CP    = 2,
  parameter int N_RP    = 4,
  parameter int BYPASS  = 1,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CP-1:0]           WP_Wen,
  input  logic [N_CP*IDX_W-1:0]     WP_DRindex,
  input  logic [N_CP*ROBEN_W-1:0]   WP_ROBEN,
  input  logic [N_CP*DATA_W-1:0]    WP_Data,
  input  logic                      Decoded_WP_Wen,
  input  logic [IDX_W-1:0]          Decoded_WP_DRindex,
  input  logic [ROBEN_W-1:0]        Decoded_WP_ROBEN,
  input  logic                      Flush,
  input  logic [N_RP*IDX_W-1:0]     RP_index,
  output logic [N_RP*DATA_W-1:0]    RP_Reg,
  output logic [N_RP*ROBEN_W-1:0]   RP_Reg_ROBEN,
  input  logic [IDX_W-1:0]          dbg_index,
  output logic [ROBEN_W-1:0]        dbg_ROBEN
);

  logic [DATA_W-1:0]  data_q [NREG];
  logic [DATA_W-1:0]  data_d [NREG];
  logic [ROBEN_W-1:0] tag_q  [NREG];
  logic [ROBEN_W-1:0] tag_d  [NREG];

  // Register 0 and out-of-range indices (non power-of-2 NREG) are never written.
  function automatic logic writable(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NREG);
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < NREG;
  endfunction

  always_comb begin
    logic [IDX_W-1:0] widx;
    for (int r = 0; r < NREG; r++) begin
      data_d[r] = data_q[r];
      tag_d[r]  = tag_q[r];
    end
    widx = '0;
    // Later ports overwrite earlier ones for data; any matching port clears the tag.
    for (int k = 0; k < N_CP; k++) begin
      widx = WP_DRindex[k*IDX_W +: IDX_W];
      if (WP_Wen[k] && writable(widx)) begin
        data_d[widx] = WP_Data[k*DATA_W +: DATA_W];
        if (tag_q[widx] == WP_ROBEN[k*ROBEN_W +: ROBEN_W])
          tag_d[widx] = '0;
      end
    end
    if (Decoded_WP_Wen && writable(Decoded_WP_DRindex))
      tag_d[Decoded_WP_DRindex] = Decoded_WP_ROBEN;
    if (Flush) begin
      for (int r = 0; r < NREG; r++)
        tag_d[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
    end
  end

  // Read ports: registered state, optionally overridden by a same-cycle matching commit.
  always_comb begin
    logic [IDX_W-1:0]   ridx;
    logic [IDX_W-1:0]   cidx;
    logic [DATA_W-1:0]  rdata;
    logic [ROBEN_W-1:0] rtag;
    RP_Reg       = '0;
    RP_Reg_ROBEN = '0;
    ridx  = '0;
    cidx  = '0;
    rdata = '0;
    rtag  = '0;
    for (int i = 0; i < N_RP; i++) begin
      ridx  = RP_index[i*IDX_W +: IDX_W];
      rdata = '0;
      rtag  = '0;
      if (in_range(ridx)) begin
        rdata = data_q[ridx];
        rtag  = tag_q[ridx];
        if (BYPASS != 0 && ridx != '0) begin
          for (int k = 0; k < N_CP; k++) begin
            cidx = WP_DRindex[k*IDX_W +: IDX_W];
            if (WP_Wen[k] && cidx == ridx &&
                WP_ROBEN[k*ROBEN_W +: ROBEN_W] == tag_q[ridx]) begin
              rdata = WP_Data[k*DATA_W +: DATA_W];
              rtag  = '0;
            end
          end
        end
      end
      RP_Reg[i*DATA_W +: DATA_W]        = rdata;
      RP_Reg_ROBEN[i*ROBEN_W +: ROBEN_W] = rtag;
    end
  end

  always_comb begin
    dbg_ROBEN = '0;
    if (in_range(dbg_index))
      dbg_ROBEN = tag_q[dbg_index];
  end

endmodule

// File: tb/tb_regfile_rob_tagged.sv
// Directed scoreboard bench for regfile_rob_tagged (default parameters, BYPASS=1).
module tb_regfile_rob_tagged;

  localparam int DATA_W  = 32;
  localparam int NREG    = 32;
  localparam int ROBEN_W = 5;
  localparam int N_CP    = 2;
  localparam int N_RP    = 4;
  localparam int IDX_W   = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_CP-1:0]         WP_Wen;
  logic [N_CP*IDX_W-1:0]   WP_DRindex;
  logic [N_CP*ROBEN_W-1:0] WP_ROBEN;
  logic [N_CP*DATA_W-1:0]  WP_Data;
  logic                    Decoded_WP_Wen;
  logic [IDX_W-1:0]        Decoded_WP_DRindex;
  logic [ROBEN_W-1:0]      Decoded_WP_ROBEN;
  logic                    Flush;
  logic [N_RP*IDX_W-1:0]   RP_index;
  logic [N_RP*DATA_W-1:0]  RP_Reg;
  logic [N_RP*ROBEN_W-1:0] RP_Reg_ROBEN;
  logic [IDX_W-1:0]        dbg_index;
  logic [ROBEN_W-1:0]      dbg_ROBEN;

  regfile_rob_tagged #(
    .DATA_W(DATA_W), .NREG(NREG), .ROBEN_W(ROBEN_W),
    .N_CP(N_CP), .N_RP(N_RP), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .WP_Wen(WP_Wen), .WP_DRindex(WP_DRindex), .WP_ROBEN(WP_ROBEN), .WP_Data(WP_Data),
    .Decoded_WP_Wen(Decoded_WP_Wen), .Decoded_WP_DRindex(Decoded_WP_DRindex),
    .Decoded_WP_ROBEN(Decoded_WP_ROBEN), .Flush(Flush),
    .RP_index(RP_index), .RP_Reg(RP_Reg), .RP_Reg_ROBEN(RP_Reg_ROBEN),
    .dbg_index(dbg_index), .dbg_ROBEN(dbg_ROBEN)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    int                 port;   // -1 selects dbg_ROBEN
    logic [DATA_W-1:0]  data;
    logic [ROBEN_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic idle();
    WP_Wen = '0; WP_DRindex = '0; WP_ROBEN = '0; WP_Data = '0;
    Decoded_WP_Wen = 1'b0; Decoded_WP_DRindex = '0; Decoded_WP_ROBEN = '0;
    Flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic commit(input int p, input int idx, input int tag, input logic [DATA_W-1:0] d);
    WP_Wen[p] = 1'b1;
    WP_DRindex[p*IDX_W +: IDX_W]   = IDX_W'(idx);
    WP_ROBEN[p*ROBEN_W +: ROBEN_W] = ROBEN_W'(tag);
    WP_Data[p*DATA_W +: DATA_W]    = d;
  endtask

  task automatic rename(input int idx, input int tag);
    Decoded_WP_Wen     = 1'b1;
    Decoded_WP_DRindex = IDX_W'(idx);
    Decoded_WP_ROBEN   = ROBEN_W'(tag);
  endtask

  // Drive a read index and push the value the port must show.
  task automatic rd(input string name, input int p, input int idx,
                    input logic [DATA_W-1:0] d, input int tag);
    exp_t e;
    RP_index[p*IDX_W +: IDX_W] = IDX_W'(idx);
    e.name = name; e.port = p; e.data = d; e.tag = ROBEN_W'(tag);
    exp_q.push_back(e);
  endtask

  task automatic dbg(input string name, input int idx, input int tag);
    exp_t e;
    dbg_index = IDX_W'(idx);
    e.name = name; e.port = -1; e.data = '0; e.tag = ROBEN_W'(tag);
    exp_q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [DATA_W-1:0]  od;
    logic [ROBEN_W-1:0] ot;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.port < 0) begin
        ot = dbg_ROBEN;
      end else begin
        od = RP_Reg[e.port*DATA_W +: DATA_W];
        ot = RP_Reg_ROBEN[e.port*ROBEN_W +: ROBEN_W];
        n_tests++;
        assert (od === e.data) else begin
          n_fail++;
          $error("FAIL %s data: got %0h expected %0h", e.name, od, e.data);
        end
      end
      n_tests++;
      assert (ot === e.tag) else begin
        n_fail++;
        $error("FAIL %s tag: got %0d expected %0d", e.name, ot, e.tag);
      end
    end
  endtask

  initial begin
    idle();
    RP_index = '0;
    dbg_index = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Reset state of indices 0..9
    for (int b = 0; b < 10; b += 4) begin
      for (int p = 0; p < N_RP; p++)
        rd("reset", p, (b + p) % 10, '0, 0);
      chk();
    end
    dbg("reset_dbg", 7, 0); chk();

    // Rename then commit, with same-cycle bypass
    rename(1, 2);
    rd("rename_not_fwd", 0, 1, '0, 0); chk();
    tick();
    rd("after_rename", 0, 1, '0, 2); dbg("after_rename_dbg", 1, 2); chk();
    commit(0, 1, 2, 32'd123);
    rd("commit_bypass", 1, 1, 32'd123, 0); chk();
    tick();
    rd("after_commit", 2, 1, 32'd123, 0); chk();

    // Stale commit keeps the younger tag
    rename(1, 2); tick();
    rename(1, 7); tick();
    commit(1, 1, 2, 32'd55);
    rd("stale_bypass", 0, 1, 32'd123, 7); chk();
    tick();
    rd("stale_after", 0, 1, 32'd55, 7); chk();

    // Rename beats commit clear on the same register
    rename(5, 3); tick();
    rename(5, 4); commit(0, 5, 3, 32'd9);
    rd("ren_vs_commit_bypass", 3, 5, 32'd9, 0); chk();
    tick();
    rd("ren_vs_commit", 3, 5, 32'd9, 4); chk();

    // Two ports commit the same register: higher port wins
    commit(0, 6, 0, 32'd1); commit(1, 6, 0, 32'd2);
    rd("dual_commit_bypass", 0, 6, 32'd2, 0); chk();
    tick();
    rd("dual_commit", 0, 6, 32'd2, 0); chk();

    // Pending tags on r1..r31, then flush together with a rename
    for (int r = 1; r < NREG; r++) begin
      rename(r, (r % 31) + 1);
      tick();
    end
    rd("pre_flush_r31", 0, 31, '0, 1); dbg("pre_flush_dbg", 3, 4); chk();
    Flush = 1'b1; rename(3, 8);
    tick();
    rd("flush_r1", 0, 1, 32'd55, 0); rd("flush_r3", 1, 3, '0, 0);
    rd("flush_r5", 2, 5, 32'd9, 0);  rd("flush_r31", 3, 31, '0, 0);
    dbg("flush_dbg", 3, 0); chk();
    rd("flush_r6", 0, 6, 32'd2, 0); chk();

    // Register 0 ignores commits and renames
    commit(0, 0, 0, 32'hFFFF_FFFF); rename(0, 5);
    rd("r0_bypass", 0, 0, '0, 0); chk();
    tick();
    rd("r0_after", 0, 0, '0, 0); dbg("r0_dbg", 0, 0); chk();

    // Reset mid-sequence overrides a same-cycle rename and commit
    rename(2, 9); tick();
    rd("pre_rst_r2", 1, 2, '0, 9); chk();
    rst = 1'b0; commit(0, 1, 0, 32'd77); rename(4, 6);
    tick();
    rst = 1'b1;
    rd("rst_r1", 0, 1, '0, 0); rd("rst_r2", 1, 2, '0, 0);
    rd("rst_r4", 2, 4, '0, 0); rd("rst_r6", 3, 6, '0, 0);
    dbg("rst_dbg", 2, 0); chk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_rob_tagged.md
# regfile_rob_tagged

Parametrised architectural register file with a per-register ROB tag (register status table) for the SSOOO out-of-order core. It has N_CP commit write ports from the ROB, one rename port from decode, N_RP combinational read ports for issue, and a flush input for misprediction recovery. It replaces the fixed 2-read/1-write RegFile.

## Interface
- DATA_W, 32, register data width
- NREG, 32, number of architectural registers; IDX_W = $clog2(NREG)
- ROBEN_W, 5, ROB tag width; tag value 0 means "no pending producer"
- N_CP, 2, number of commit write ports
- N_RP, 4, number of read ports
- BYPASS, 1, 1 = same-cycle commit forwarded to read ports; 0 = reads show registered state only
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- WP_Wen  in  N_CP  commit write enable per port
- WP_DRindex  in  N_CP*IDX_W  commit destination index, port k at [k*IDX_W +: IDX_W]
- WP_ROBEN  in  N_CP*ROBEN_W  ROB tag of the committing instruction
- WP_Data  in  N_CP*DATA_W  commit data
- Decoded_WP_Wen  in  1  rename enable from decode
- Decoded_WP_DRindex  in  IDX_W  renamed destination register
- Decoded_WP_ROBEN  in  ROBEN_W  newly allocated ROB tag (never 0 when enabled)
- Flush  in  1  clear all tags
- RP_index  in  N_RP*IDX_W  read indices
- RP_Reg  out  N_RP*DATA_W  read data
- RP_Reg_ROBEN  out  N_RP*ROBEN_W  read tag (0 = value ready)
- dbg_index  in  IDX_W  debug read index
- dbg_ROBEN  out  ROBEN_W  tag of register dbg_index

## Operation
- State: data[NREG] of DATA_W, tag[NREG] of ROBEN_W.
- Register 0: data and tag are constant 0; commits and renames to index 0 are ignored.
- Commit port k (WP_Wen[k], index r != 0): data[r] <= WP_Data[k] unconditionally; tag[r] <= 0 only if tag[r] == WP_ROBEN[k], otherwise the tag is kept (a younger producer is pending).
- Several commit ports targeting the same r in one cycle: the highest-numbered port wins for data; the tag is cleared if any matching port matches.
- Rename (Decoded_WP_Wen, index r != 0): tag[r] <= Decoded_WP_ROBEN. Rename beats a same-cycle commit clear on the same r. Commit data is still written.
- Flush: every tag <= 0. Flush beats rename in the same cycle. Commits in the same cycle still write data.
- Read port i, index r (combinational):
  - BYPASS=0: returns data[r] and tag[r].
  - BYPASS=1: if a commit port with WP_Wen set targets r and its WP_ROBEN equals tag[r], returns that port's WP_Data (highest matching port) and tag 0.
  - Otherwise returns data[r] and tag[r].
  - Rename is never forwarded; a rename appears on reads in the next cycle.
- dbg_ROBEN = tag[dbg_index] (registered state, no bypass).
- Indices >= NREG, when NREG is not a power of 2: writes ignored, reads return 0.

## Timing
- Reset (rst == 0 at a rising edge): all data and tags go to 0. Reset overrides every write, rename and flush in that cycle. From the following cycle all read outputs and dbg_ROBEN are 0.
- Write latency: 1 cycle (visible on reads after the edge). With BYPASS=1, a matching commit is visible in the same cycle.
- Read latency: 0 (combinational from RP_index and state).
- No handshake: every enabled request is accepted every cycle. No back-pressure.

## Test plan
- Reset: rst=0 for one edge, then read indices 0..9 -> RP_Reg=0, RP_Reg_ROBEN=0 on all ports.
- Rename then commit: rename r1 tag 2. Next cycle commit r1 tag 2, data 123. After the edge -> r1 = 123, tag 0. With BYPASS=1, the read in the commit cycle already shows 123 with tag 0.
- Stale commit: rename r1 tag 2, then rename r1 tag 7, then commit r1 tag 2, data 55 -> data 55, tag stays 7. With BYPASS=1 the commit-cycle read shows the old data with tag 7.
- Same-cycle conflicts:
  - Tag 3 pending on r5; rename r5 tag 4 and commit r5 tag 3, data 9 in one cycle -> r5 data 9, tag 4.
  - Ports 0 and 1 both commit r6 with data 1 and 2 -> data 2.
- Flush: tags pending on r1..r31, assert Flush together with rename r3 tag 8 -> all tags 0, including r3; data unchanged.
- Register 0: commit r0 data 0xFFFF_FFFF and rename r0 tag 5 -> reads of r0 return 0, tag 0. Asserting rst mid-sequence clears pending tags and data on the next edge.
